// File: rtl/iomem_arbiter_pkg.sv
// iomem_arbiter_pkg
// Shared definitions for the iomem bus arbiters. This package holds the
// arbiter state encoding and the default timeout constants. Wider N-master
// variants can reuse them so that every arbiter reports the same abort data.
// There are no ports, because this file is a package.
package iomem_arbiter_pkg;

  // IDLE:   nobody owns the slave.
  // GNT0/1: master 0 or 1 owns the slave.
  // REL:    one dead cycle after any ownership ends.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2,
    ST_REL  = 2'd3
  } arb_state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 4095;
  localparam logic [31:0] DEFAULT_TIMEOUT_RDATA  = 32'hDEAD_BEEF;

endpackage

// File: rtl/iomem_arbiter.sv
// iomem_arbiter
// Two-master, one-slave arbiter for the picorv32-style iomem bus (valid/ready).
// Contention between the masters is resolved round-robin. Every transaction is
// followed by a one-cycle release gap. A bounded wait aborts a transaction that
// the slave never answers.
//
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   m0_* / m1_*                    master request in (valid/addr/wdata/wstrb),
//                                  completion out (ready pulse, rdata)
//   s_valid/s_addr/s_wdata/s_wstrb forwarded request to the shared slave
//   s_ready/s_rdata                slave completion and read data
//   busy                           high whenever the arbiter is not idle
//   timeout_err                    sticky flag; set by any aborted transaction
module iomem_arbiter
  import iomem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter logic [31:0] TIMEOUT_RDATA  = DEFAULT_TIMEOUT_RDATA
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        busy,
  output logic        timeout_err
);

  // Keep the counter at least one bit wide so that TIMEOUT_CYCLES=0
  // (timeout disabled) still elaborates.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  arb_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  logic granted;
  logic gnt_is_m1;
  logic gnt_valid;
  logic timeout_hit;
  logic complete;

  assign granted     = (state_q == ST_GNT0) || (state_q == ST_GNT1);
  assign gnt_is_m1   = (state_q == ST_GNT1);
  assign gnt_valid   = gnt_is_m1 ? m1_valid : m0_valid;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == CNT_TERM) && !s_ready;
  // A master that drops valid while it is granted gets no completion pulse.
  // In that case the arbiter only releases the bus.
  assign complete    = granted && gnt_valid && (s_ready || timeout_hit);

  // State, fairness pointer, wait counter and sticky error register.
  // Reset leaves last_grant at 1, so master 0 wins the first tie after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic. In a grant state the checks run in this order:
  //   1. the granted master dropped valid (abandon the transaction);
  //   2. the slave completed (normal completion);
  //   3. the timeout expired (abort).
  // Because completion is checked before the timeout, s_ready on the terminal
  // count cycle is a normal completion. An aborted transaction still counts
  // as service for round-robin purposes, so last_grant moves on.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_IDLE: begin
        wait_cnt_d = '0;
        if (m0_valid && m1_valid) begin
          state_d = last_grant_q ? ST_GNT0 : ST_GNT1;
        end else if (m0_valid) begin
          state_d = ST_GNT0;
        end else if (m1_valid) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (!gnt_valid) begin
          state_d    = ST_REL;
          wait_cnt_d = '0;
        end else if (s_ready) begin
          state_d      = ST_REL;
          last_grant_d = gnt_is_m1;
          wait_cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d       = ST_REL;
          last_grant_d  = gnt_is_m1;
          wait_cnt_d    = '0;
          timeout_err_d = 1'b1;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_REL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus outputs are decoded from the state register only. Because the state
  // register resets asynchronously, s_valid, busy and the ready pulses drop
  // as soon as resetn asserts, without waiting for a clock edge.
  // Read data is forced to zero outside a ready pulse.
  always_comb begin
    s_valid  = granted;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    if (state_q == ST_GNT0) begin
      s_addr   = m0_addr;
      s_wdata  = m0_wdata;
      s_wstrb  = m0_wstrb;
      m0_ready = complete;
      m0_rdata = complete ? (s_ready ? s_rdata : TIMEOUT_RDATA) : '0;
    end else if (state_q == ST_GNT1) begin
      s_addr   = m1_addr;
      s_wdata  = m1_wdata;
      s_wstrb  = m1_wstrb;
      m1_ready = complete;
      m1_rdata = complete ? (s_ready ? s_rdata : TIMEOUT_RDATA) : '0;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_iomem_arbiter.sv
// tb_iomem_arbiter
// Directed, self-checking bench for iomem_arbiter. The DUT is built with an
// 8-cycle timeout. A small slave model answers with a programmable latency,
// or stays silent. Each expected completion is queued when its request is
// driven and checked when a ready pulse appears.
module tb_iomem_arbiter;

  typedef struct {
    logic        master;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        busy;
  logic        timeout_err;

  int          total = 0;
  int          bad = 0;
  exp_t        expQ[$];
  logic [31:0] capAddr, capWdata;
  logic [3:0]  capWstrb;
  int          slaveLatency;
  bit          slaveMute;
  logic [31:0] slaveData;

  iomem_arbiter #(
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_RDATA (32'hDEAD_BEEF)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0_valid   (m0_valid),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_wstrb   (m0_wstrb),
    .m0_ready   (m0_ready),
    .m0_rdata   (m0_rdata),
    .m1_valid   (m1_valid),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_wstrb   (m1_wstrb),
    .m1_ready   (m1_ready),
    .m1_rdata   (m1_rdata),
    .s_valid    (s_valid),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_ready    (s_ready),
    .s_rdata    (s_rdata),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  // 10 ns free-running clock; the DUT uses the rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model. It counts granted cycles (s_valid high) and pulses s_ready
  // with slaveData on the slaveLatency-th granted cycle, so latency 1 means
  // an immediate answer. When slaveMute is set it never answers.
  initial begin
    int grantCycles;
    grantCycles = 0;
    s_ready = 1'b0;
    s_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      s_ready = 1'b0;
      s_rdata = '0;
      if (!s_valid) begin
        grantCycles = 0;
      end else if (!slaveMute) begin
        grantCycles++;
        if (grantCycles == slaveLatency) begin
          s_ready = 1'b1;
          s_rdata = slaveData;
        end
      end
    end
  end

  // Drive one master's request lines.
  task automatic applyStimulus(input bit master, input bit valid, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb);
    if (master) begin
      m1_valid = valid;
      m1_addr  = addr;
      m1_wdata = wdata;
      m1_wstrb = wstrb;
    end else begin
      m0_valid = valid;
      m0_addr  = addr;
      m0_wdata = wdata;
      m0_wstrb = wstrb;
    end
  endtask

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Wait (bounded) for a ready pulse on either master, then check it against
  // the oldest queued expectation. The forwarded request is captured at the
  // same moment. 'waited' counts falling edges from the call to the pulse.
  task automatic waitReady(input int maxCycles, output int waited);
    bit   seen;
    exp_t e;
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < maxCycles) begin
      @(negedge clk);
      waited++;
      if (m0_ready || m1_ready) seen = 1'b1;
    end
    total++;
    assert (seen === 1'b1)
    else begin
      bad++;
      $error("[TB] FAIL ready_wait observed=%0d expected=1", seen);
    end
    if (seen) begin
      capAddr  = s_addr;
      capWdata = s_wdata;
      capWstrb = s_wstrb;
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $error("[TB] FAIL scoreboard observed=unexpected_ready expected=empty");
      end else begin
        e = expQ.pop_front();
        checkOutput("grant_master", {31'd0, m1_ready}, {31'd0, e.master});
        checkOutput("single_ready", {31'd0, m0_ready & m1_ready}, 32'd0);
        checkOutput("ready_rdata", e.master ? m1_rdata : m0_rdata, e.rdata);
      end
    end
  endtask

  // Wait (bounded) until the slave side sees a request.
  task automatic waitGrant(input int maxCycles);
    bit seen;
    int n;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < maxCycles) begin
      @(negedge clk);
      n++;
      if (s_valid) seen = 1'b1;
    end
    total++;
    assert (seen === 1'b1)
    else begin
      bad++;
      $error("[TB] FAIL grant_wait observed=%0d expected=1", seen);
    end
  endtask

  // Directed sequence. Requests are driven 1 ns after a rising edge, and
  // outputs are checked on falling edges.
  initial begin
    int          waited;
    logic [31:0] d0, d1, a0, a1;
    resetn       = 1'b0;
    slaveMute    = 1'b0;
    slaveLatency = 1;
    slaveData    = '0;
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    #2;
    checkOutput("rst_s_valid", {31'd0, s_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
    checkOutput("rst_m1_ready", {31'd0, m1_ready}, 32'd0);
    checkOutput("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    checkOutput("rst_m0_rdata", m0_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] contention rounds");
    slaveLatency = 2;
    for (int r = 0; r < 2; r++) begin
      a0 = 32'h0600_0100 + 32'(r);
      a1 = 32'h0700_0200 + 32'(r);
      d0 = 32'h1000_0000 + 32'(r);
      d1 = 32'h2000_0000 + 32'(r);
      slaveData = d0;
      expQ.push_back(exp_t'{1'b0, d0});
      applyStimulus(1'b0, 1'b1, a0, '0, '0);
      applyStimulus(1'b1, 1'b1, a1, '0, '0);
      waitReady(20, waited);
      checkOutput("rr_addr_m0", capAddr, a0);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
      slaveData = d1;
      expQ.push_back(exp_t'{1'b1, d1});
      waitReady(20, waited);
      checkOutput("rr_addr_m1", capAddr, a1);
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 1'b0, '0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
    end

    $display("[TB] solo read");
    slaveLatency = 3;
    slaveData    = 32'h1234_5678;
    expQ.push_back(exp_t'{1'b0, 32'h1234_5678});
    applyStimulus(1'b0, 1'b1, 32'h0600_0010, '0, '0);
    waitReady(20, waited);
    checkOutput("solo_latency", 32'(waited), 32'd4);
    checkOutput("solo_addr", capAddr, 32'h0600_0010);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checkOutput("rel_s_valid", {31'd0, s_valid}, 32'd0);
    checkOutput("rel_busy", {31'd0, busy}, 32'd1);
    checkOutput("rel_m0_ready", {31'd0, m0_ready}, 32'd0);
    checkOutput("rel_m0_rdata", m0_rdata, 32'd0);
    @(negedge clk);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] m1 write");
    slaveLatency = 1;
    slaveData    = 32'h5555_0000;
    expQ.push_back(exp_t'{1'b1, 32'h5555_0000});
    applyStimulus(1'b1, 1'b1, 32'h0300_0004, 32'h0000_00A5, 4'b0001);
    waitReady(20, waited);
    checkOutput("wr_latency", 32'(waited), 32'd2);
    checkOutput("wr_addr", capAddr, 32'h0300_0004);
    checkOutput("wr_wdata", capWdata, 32'h0000_00A5);
    checkOutput("wr_wstrb", {28'd0, capWstrb}, 32'h1);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] timeout race");
    slaveLatency = 8;
    slaveData    = 32'h0BAD_F00D;
    expQ.push_back(exp_t'{1'b0, 32'h0BAD_F00D});
    applyStimulus(1'b0, 1'b1, 32'h0600_0020, '0, '0);
    waitReady(30, waited);
    checkOutput("race_latency", 32'(waited), 32'd9);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checkOutput("race_timeout_err", {31'd0, timeout_err}, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] timeout");
    slaveMute = 1'b1;
    expQ.push_back(exp_t'{1'b1, 32'hDEAD_BEEF});
    applyStimulus(1'b1, 1'b1, 32'h0600_0030, '0, '0);
    waitReady(30, waited);
    checkOutput("to_latency", 32'(waited), 32'd9);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    @(negedge clk);
    checkOutput("to_err_set", {31'd0, timeout_err}, 32'd1);
    @(posedge clk);
    #1;
    slaveMute    = 1'b0;
    slaveLatency = 2;
    slaveData    = 32'hCAFE_0001;
    expQ.push_back(exp_t'{1'b0, 32'hCAFE_0001});
    applyStimulus(1'b0, 1'b1, 32'h0600_0040, '0, '0);
    waitReady(20, waited);
    checkOutput("post_to_latency", 32'(waited), 32'd3);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checkOutput("to_err_sticky", {31'd0, timeout_err}, 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] async reset mid-grant");
    slaveMute = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h0600_0050, '0, '0);
    waitGrant(10);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("arst_s_valid", {31'd0, s_valid}, 32'd0);
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_m0_ready", {31'd0, m0_ready}, 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    checkOutput("arst_err_clr", {31'd0, timeout_err}, 32'd0);
    slaveMute    = 1'b0;
    slaveLatency = 1;
    slaveData    = 32'h7777_0001;
    expQ.push_back(exp_t'{1'b1, 32'h7777_0001});
    applyStimulus(1'b1, 1'b1, 32'h0700_0060, '0, '0);
    waitReady(20, waited);
    checkOutput("arst_m1_latency", 32'(waited), 32'd2);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] valid drop while granted");
    slaveMute = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h0600_0070, '0, '0);
    waitGrant(10);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checkOutput("drop_no_ready", {31'd0, m0_ready}, 32'd0);
    checkOutput("drop_s_valid_held", {31'd0, s_valid}, 32'd1);
    @(negedge clk);
    checkOutput("drop_rel_s_valid", {31'd0, s_valid}, 32'd0);
    checkOutput("drop_rel_busy", {31'd0, busy}, 32'd1);
    checkOutput("drop_rel_ready", {31'd0, m0_ready}, 32'd0);
    @(negedge clk);
    checkOutput("drop_idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("drop_timeout_err", {31'd0, timeout_err}, 32'd0);
    checkOutput("sb_empty", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iomem_arbiter.md
Name: iomem_arbiter

Overview:
Two-master, one-slave arbiter for the memory-mapped iomem peripheral bus (picorv32 valid/ready style). Lets the CPU (m0) and a second bus master (m1, e.g. a console/file streamer) share one slow peripheral such as the SD-card or SPI-flash controller. Round-robin on contention, a one-cycle release gap between transactions, and a bounded-wait timeout so a hung peripheral cannot lock up a master.

Parameters:
TIMEOUT_CYCLES, 4095, cycles a granted transaction may wait for s_ready before the arbiter aborts it; 0 disables the timeout.
TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned to the master on timeout.

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
m0_valid  input  1  CPU request; held until m0_ready
m0_addr  input  32  CPU address
m0_wdata  input  32  CPU write data
m0_wstrb  input  4  CPU byte strobes; 0 = read
m0_ready  output  1  one-cycle completion pulse to CPU
m0_rdata  output  32  CPU read data, valid while m0_ready=1
m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata  same as m0_*, for master 1
s_valid  output  1  request to shared slave
s_addr  output  32  forwarded address
s_wdata  output  32  forwarded write data
s_wstrb  output  4  forwarded strobes
s_ready  input  1  slave completion pulse
s_rdata  input  32  slave read data
busy  output  1  high in any state except IDLE
timeout_err  output  1  sticky; set on any timeout, cleared only by reset

Behaviour:
- Reset (async, resetn=0): state=IDLE, last_grant=1 (m0 wins the first tie), wait_cnt=0, timeout_err=0. While in reset, s_valid, m0_ready, m1_ready and busy are 0. Because s_valid and the ready outputs are decoded from state, they drop immediately when reset asserts mid-transaction.
- States: IDLE, GNT0, GNT1, REL (release).
- IDLE:
  - only m0_valid → GNT0; only m1_valid → GNT1.
  - both → grant the master not equal to last_grant.
  - s_ready is ignored in IDLE.
- GNT0/GNT1:
  - s_valid = 1. s_addr/s_wdata/s_wstrb are muxed combinationally from the granted master.
  - The ungranted master sees ready=0.
  - On s_ready=1: granted mN_ready=1 in the same cycle, with mN_rdata=s_rdata (combinational pass-through). Then last_grant←N, wait_cnt←0, next state REL.
- Latency: a request seen in IDLE at edge n gives s_valid high from n+1. Minimum turnaround is request→ready in 2 cycles if the slave answers immediately.
- REL:
  - s_valid = 0 for exactly one cycle, so masters can drop valid (matches the peripherals' valid && !ready gating).
  - Then → IDLE. A master still holding valid is re-arbitrated in IDLE on the next cycle.
- Timeout (TIMEOUT_CYCLES>0):
  - wait_cnt increments each GNT cycle without s_ready.
  - When wait_cnt == TIMEOUT_CYCLES-1 and s_ready=0: mN_ready=1 with mN_rdata=TIMEOUT_RDATA, timeout_err←1, → REL.
  - If s_ready arrives on that same cycle, the normal completion wins and timeout_err is unchanged.
  - wait_cnt width is clog2(TIMEOUT_CYCLES+1) and it saturates, never wrapping.
- Master drops valid while granted (protocol violation):
  - → REL with no ready pulse and s_valid low next cycle.
  - last_grant is unchanged and timeout_err is not set.
- mN_rdata is 0 whenever mN_ready=0.
- Writes complete identically to reads; rdata is don't-care to the master.

Decomposition:
- Shared package: state encoding constants (IDLE/GNT0/GNT1/REL) and the default TIMEOUT_RDATA constant, reused by later N-master variants.
- No sub-module needed. An optional iomem_rr_pick (2-input round-robin picker) is the natural split if the arbiter is later widened.

Test Plan:
1. Solo read: m0 reads 0x0600_0010; slave returns 0x1234_5678 two cycles after s_valid → m0_ready pulses 1 cycle with rdata 0x1234_5678; s_valid low the following cycle (REL); m1_ready stays 0.
2. Contention/fairness: m0 and m1 assert in the same cycle, repeated 4 times → grant order m0, m1, m0, m1; the loser sees no ready and its valid is held throughout.
3. Timeout: TIMEOUT_CYCLES=8, slave never answers m1 → m1_ready on the 8th granted cycle with rdata 0xDEAD_BEEF; timeout_err=1 and stays 1 through later successful transactions.
4. Timeout race: s_ready arrives exactly on the terminal count cycle → slave data returned and timeout_err remains 0.
5. Async reset mid-grant: assert resetn=0 between edges while in GNT0 → s_valid and busy drop without a clock edge; after release, m1 alone requesting is granted first (IDLE, last_grant=1).
6. Write path plus valid drop: m1 writes 0xA5 with wstrb=0001 → s_wstrb/s_wdata/s_addr match m1 exactly. Then m0 drops valid mid-grant → no m0_ready, REL, IDLE, timeout_err=0.
